i2c_master_ctrl: RTL

- Single-byte I2C master engine; drives the bus lines that the verification interface's `scl`/`sda` signals observe.
- Accepts one command per transaction: 7-bit address, R/W bit and write byte.
- Generates START, address, ACK, data, ACK/NACK and STOP with open-drain SDA signalling.
- Returns the read byte and an acknowledge-error flag.

---
 rtl/i2c_master_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Each bit period has four quarters of CLK_DIV clocks; SCL is high in q2/q3.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ack_err,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WRITE, S_WACK, S_READ, S_RACK, S_STOP
    } state_t;

    state_t state, state_next;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       qtr;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_shift;
    logic [7:0]       rx_shift;
    logic [7:0]       wdata_q;
    logic             rw_q;
    logic             sample_q;
    logic             tick;
    logic             sample_pt;
    logic             bit_end;

    assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign sample_pt = tick && (qtr == 2'd2);
    assign bit_end   = tick && (qtr == 2'd3);
    assign ready     = (state == S_IDLE);
    assign busy      = !ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Bus levels are decoded from state and quarter so a reset releases both lines at once.
    always_comb begin
        state_next = state;
        scl        = 1'b1;
        sda_oe     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_START;
            end
            S_START: begin
                sda_oe = qtr[1];
                if (bit_end) state_next = S_ADDR;
            end
            S_ADDR: begin
                scl    = qtr[1];
                sda_oe = !tx_shift[7];
                if (bit_end && bit_cnt == 3'd0) state_next = S_AACK;
            end
            S_AACK: begin
                scl = qtr[1];
                if (bit_end) begin
                    if (sample_q)  state_next = S_STOP;
                    else if (rw_q) state_next = S_READ;
                    else           state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                scl    = qtr[1];
                sda_oe = !tx_shift[7];
                if (bit_end && bit_cnt == 3'd0) state_next = S_WACK;
            end
            S_WACK: begin
                scl = qtr[1];
                if (bit_end) state_next = S_STOP;
            end
            S_READ: begin
                scl = qtr[1];
                if (bit_end && bit_cnt == 3'd0) state_next = S_RACK;
            end
            S_RACK: begin
                scl = qtr[1];
                if (bit_end) state_next = S_STOP;
            end
            S_STOP: begin
                scl    = qtr[1];
                sda_oe = (qtr != 2'd3);
                if (bit_end) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Shifters advance at the end of a bit so the next MSB appears exactly at q0 entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            qtr      <= 2'd0;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            wdata_q  <= 8'h00;
            rw_q     <= 1'b0;
            sample_q <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'h00;
            ack_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                div_cnt <= '0;
                qtr     <= 2'd0;
                if (start) begin
                    tx_shift <= {addr, rw};
                    wdata_q  <= wdata;
                    rw_q     <= rw;
                    bit_cnt  <= 3'd7;
                    ack_err  <= 1'b0;
                end
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) qtr <= qtr + 2'd1;
                if (sample_pt) begin
                    sample_q <= sda_i;
                    if (state == S_READ) rx_shift <= {rx_shift[6:0], sda_i};
                end
                if (bit_end) begin
                    case (state)
                        S_ADDR, S_WRITE: begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            bit_cnt  <= bit_cnt - 3'd1;
                        end
                        S_READ: bit_cnt <= bit_cnt - 3'd1;
                        S_AACK: begin
                            if (sample_q) begin
                                ack_err <= 1'b1;
                            end else begin
                                tx_shift <= wdata_q;
                                bit_cnt  <= 3'd7;
                            end
                        end
                        S_WACK: if (sample_q) ack_err <= 1'b1;
                        S_RACK: rdata <= rx_shift;
                        S_STOP: done  <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
